// File: rtl/rms_sumsq.sv
// Streaming mean-of-squares front end: squares N_ELEM signed activations per
// vector, then emits a saturated, EPS-biased mean square as a one-cycle pulse.
module rms_sumsq #(
   parameter int unsigned N_ELEM = 64,
   parameter int unsigned LOG2_N = 6,
   parameter int unsigned X_W    = 8,
   parameter int unsigned D_W    = 14,
   parameter int unsigned EPS    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  x_valid_i,
   input  logic signed [X_W-1:0] x_i,
   input  logic                  x_last_i,
   output logic                  x_ready_o,
   output logic                  d_valid_o,
   output logic [D_W-1:0]        d_o,
   output logic                  frame_err_o
);

   localparam int unsigned SQ_W  = 2 * X_W;
   localparam int unsigned ACC_W = SQ_W + LOG2_N;
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic [SUM_W-1:0] D_MAX = SUM_W'({D_W{1'b1}});

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      WAIT = 2'd1,
      SUM  = 2'd2,
      EMIT = 2'd3
   } state_t;

   state_t state, next_state;

   logic [LOG2_N-1:0]      cnt;
   logic [SQ_W-1:0]        sq_r;
   logic [ACC_W-1:0]       acc;
   logic                   acc_en_r;
   logic                   err_r;

   logic                   accept_c;
   logic                   last_c;
   logic                   bad_last_c;
   logic signed [SQ_W-1:0] prod_c;
   logic [SUM_W-1:0]       mean_c;
   logic [SUM_W-1:0]       biased_c;
   logic [D_W-1:0]         d_sat_c;

   assign accept_c   = x_valid_i & x_ready_o;
   assign last_c     = (cnt == LOG2_N'(N_ELEM - 1));
   assign bad_last_c = x_last_i ^ last_c;
   assign prod_c     = SQ_W'(x_i) * SQ_W'(x_i);

   // Truncating mean, bias, and saturation to the output range
   always_comb begin
      mean_c   = SUM_W'(acc >> LOG2_N);
      biased_c = mean_c + SUM_W'(EPS);
      d_sat_c  = (biased_c > D_MAX) ? D_MAX[D_W-1:0] : biased_c[D_W-1:0];
   end

   // Next-state logic: collect a vector, drain the squarer, sum, emit
   always_comb begin
      next_state = state;
      unique case (state)
         ACC:  if (accept_c && last_c) next_state = WAIT;
         WAIT: next_state = SUM;
         SUM:  next_state = EMIT;
         EMIT: next_state = ACC;
         default: next_state = ACC;
      endcase
   end

   // State register; ready is registered from the upcoming state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ACC;
         x_ready_o <= 1'b0;
      end else begin
         state     <= next_state;
         x_ready_o <= (next_state == ACC);
      end
   end

   // Squarer stage, element counter, and accumulate enable delayed to match sq_r
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt      <= '0;
         sq_r     <= '0;
         acc_en_r <= 1'b0;
      end else begin
         acc_en_r <= accept_c;
         if (accept_c) begin
            sq_r <= $unsigned(prod_c);
            cnt  <= cnt + LOG2_N'(1);
         end
      end
   end

   // Accumulator and sticky framing error, both cleared while emitting
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc   <= '0;
         err_r <= 1'b0;
      end else if (state == EMIT) begin
         acc   <= '0;
         err_r <= 1'b0;
      end else begin
         if (acc_en_r) acc <= acc + ACC_W'(sq_r);
         if (accept_c && bad_last_c) err_r <= 1'b1;
      end
   end

   // Result registers: pulse valid for one cycle, d_o holds until next result
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_valid_o   <= 1'b0;
         frame_err_o <= 1'b0;
         d_o         <= '0;
      end else begin
         d_valid_o   <= (state == SUM);
         frame_err_o <= (state == SUM) & err_r;
         if (state == SUM) d_o <= d_sat_c;
      end
   end

endmodule

// File: tb/tb_rms_sumsq.sv
// Scoreboard bench for rms_sumsq: driver pushes model results, monitor checks pulses.
module tb_rms_sumsq;

   localparam int N    = 64;
   localparam int DW   = 14;
   localparam int EPS  = 1;
   localparam int DMAX = (1 << DW) - 1;
   localparam logic [63:0] CLEAN = 64'(1) << 63;

   typedef int vec_t[N];
   typedef struct {
      int d;
      int ferr;
      int cyc;
   } exp_t;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              x_valid_i;
   logic signed [7:0] x_i;
   logic              x_last_i;
   logic              x_ready_o;
   logic              d_valid_o;
   logic [DW-1:0]     d_o;
   logic              frame_err_o;

   rms_sumsq dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .x_valid_i  (x_valid_i),
      .x_i        (x_i),
      .x_last_i   (x_last_i),
      .x_ready_o  (x_ready_o),
      .d_valid_o  (d_valid_o),
      .d_o        (d_o),
      .frame_err_o(frame_err_o)
   );

   always #5 clk_i = ~clk_i;

   int   cyc = 0;
   exp_t sbq[$];
   int   dv_hist[$];
   int   tests = 0;
   int   fails = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: mean of squares from plain arithmetic, framing from the mask
   function automatic exp_t model(input vec_t vals, input logic [63:0] lastm, input int lat);
      exp_t   e;
      longint s = 0;
      longint m;
      int     err = 0;
      for (int i = 0; i < N; i++) begin
         s += longint'(vals[i]) * longint'(vals[i]);
         if (lastm[i] != (i == N - 1)) err = 1;
      end
      m = s / N + EPS;
      if (m > DMAX) m = DMAX;
      e.d = int'(m);
      e.ferr = err;
      e.cyc = lat;
      return e;
   endfunction

   // Monitor: every result pulse must match the oldest expected entry
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (d_valid_o) begin
            dv_hist.push_back(cyc);
            if (sbq.size() == 0) begin
               check("spurious_d_valid", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("d_o", int'(d_o), e.d);
               check("frame_err_o", int'(frame_err_o), e.ferr);
               check("latency_cycle", cyc, e.cyc);
            end
         end else if (frame_err_o) begin
            check("frame_err_outside_valid", 1, 0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_i);
         x_valid_i = 1'b0;
         x_last_i  = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, int'(x_ready_o), 0);
      check({tag, "_d_valid"}, int'(d_valid_o), 0);
      check({tag, "_d_o"}, int'(d_o), 0);
      check({tag, "_frame_err"}, int'(frame_err_o), 0);
   endtask

   // Drive one vector; abort_at >= 0 pulses reset once that many beats are in
   task automatic send_vector(input vec_t vals, input logic [63:0] lastm, input bit gaps,
                              input int abort_at, output int stall0);
      int i = 0;
      int guard = 0;
      int acc_cyc = 0;
      stall0 = 0;
      while (i < N) begin
         @(negedge clk_i);
         if (i == abort_at) begin
            rst_ni    = 1'b0;
            x_valid_i = 1'b0;
            x_last_i  = 1'b0;
            #1;
            check_reset_outputs("midreset");
            @(negedge clk_i);
            rst_ni = 1'b1;
            return;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            x_valid_i = 1'b0;
            x_last_i  = 1'b0;
         end else begin
            x_valid_i = 1'b1;
            x_i       = 8'(vals[i]);
            x_last_i  = lastm[i];
            if (x_ready_o) begin
               acc_cyc = cyc;
               i++;
            end else if (i == 0) begin
               stall0++;
            end
         end
         guard++;
         if (guard > 2000) begin
            check("send_timeout", i, N);
            return;
         end
      end
      sbq.push_back(model(vals, lastm, acc_cyc + 3));
   endtask

   vec_t v;
   int   stall;

   initial begin
      rst_ni    = 1'b0;
      x_valid_i = 1'b0;
      x_i       = '0;
      x_last_i  = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      check("ready_before_first_edge", int'(x_ready_o), 0);
      @(negedge clk_i);
      check("ready_after_first_edge", int'(x_ready_o), 1);

      // All ones -> 2
      for (int i = 0; i < N; i++) v[i] = 1;
      send_vector(v, CLEAN, 1'b0, -1, stall);
      idle(5);
      // All -128 -> saturates
      for (int i = 0; i < N; i++) v[i] = -128;
      send_vector(v, CLEAN, 1'b0, -1, stall);
      idle(5);
      // All zeros -> EPS only
      for (int i = 0; i < N; i++) v[i] = 0;
      send_vector(v, CLEAN, 1'b0, -1, stall);
      idle(5);
      // Half 16s, half 0s -> 129
      for (int i = 0; i < N; i++) v[i] = (i < 32) ? 16 : 0;
      send_vector(v, CLEAN, 1'b0, -1, stall);
      idle(5);

      // Back-to-back random vectors with valid held high
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255)) - 128;
      send_vector(v, CLEAN, 1'b0, -1, stall);
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255)) - 128;
      send_vector(v, CLEAN, 1'b0, -1, stall);
      check("b2b_ready_low_cycles", stall, 3);
      idle(8);
      if (dv_hist.size() >= 2)
         check("b2b_pulse_spacing", dv_hist[dv_hist.size()-1] - dv_hist[dv_hist.size()-2], N + 3);
      else
         check("b2b_pulse_count", dv_hist.size(), 2);

      // Misframed (last on beat 10 only), then a clean vector
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255)) - 128;
      send_vector(v, 64'(1) << 10, 1'b0, -1, stall);
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255)) - 128;
      send_vector(v, CLEAN, 1'b0, -1, stall);
      idle(5);

      // Reset at beat 40 with gaps, then all 3s -> 10
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255)) - 128;
      send_vector(v, CLEAN, 1'b1, 40, stall);
      for (int i = 0; i < N; i++) v[i] = 3;
      send_vector(v, CLEAN, 1'b1, -1, stall);
      idle(5);

      // Random vectors, random gaps, occasional misframing
      for (int k = 0; k < 8; k++) begin
         logic [63:0] lm;
         lm = CLEAN;
         if ($urandom_range(0, 2) == 0) lm = lm ^ (64'(1) << $urandom_range(0, 63));
         for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255)) - 128;
         send_vector(v, lm, 1'b1, -1, stall);
         if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 4)));
      end
      idle(2);

      for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge clk_i);
      check("scoreboard_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
